// File: rtl/fetch_unit_1stage.sv
// Instruction fetch front end for the single-stage RV32 core: owns the PC,
// issues one outstanding imem request at a time and buffers the returned word.
module fetch_unit_1stage #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                clock,
    input  logic                reset,
    output logic                io_imem_req_valid,
    input  logic                io_imem_req_ready,
    output logic [PC_WIDTH-1:0] io_imem_req_addr,
    input  logic                io_imem_resp_valid,
    input  logic [31:0]         io_imem_resp_data,
    input  logic                io_ctl_stall,
    input  logic [2:0]          io_ctl_pc_sel,
    input  logic [2:0]          io_ctl_pc_sel_no_xept,
    input  logic [PC_WIDTH-1:0] io_br_target,
    input  logic [PC_WIDTH-1:0] io_jmp_target,
    input  logic [PC_WIDTH-1:0] io_jalr_target,
    input  logic [PC_WIDTH-1:0] io_evec,
    output logic                io_dat_imiss,
    output logic                io_dat_inst_misaligned,
    output logic [31:0]         io_inst,
    output logic                io_inst_valid,
    output logic [PC_WIDTH-1:0] io_pc
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [PC_WIDTH-1:0] PC_INC   = {{(PC_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [PC_WIDTH-1:0] LSB_MASK = {{(PC_WIDTH-1){1'b1}}, 1'b0};

    logic [1:0]          state_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic [31:0]         inst_r;
    logic                inst_valid_r;
    logic [PC_WIDTH-1:0] next_pc_s;
    logic [PC_WIDTH-1:0] jalr_clr_s;
    logic                misaligned_s;

    // Next-PC mux; unused select codes fall through to sequential fetch.
    function automatic logic [PC_WIDTH-1:0] next_pc_f(
        input logic [2:0]          sel,
        input logic [PC_WIDTH-1:0] pc,
        input logic [PC_WIDTH-1:0] br,
        input logic [PC_WIDTH-1:0] jmp,
        input logic [PC_WIDTH-1:0] jalr,
        input logic [PC_WIDTH-1:0] evec
    );
        logic [PC_WIDTH-1:0] res;
        case (sel)
            3'd1:    res = br;
            3'd2:    res = jmp;
            3'd3:    res = jalr;
            3'd4:    res = evec;
            default: res = pc + PC_INC;
        endcase
        return res;
    endfunction

    assign jalr_clr_s = io_jalr_target & LSB_MASK;
    assign next_pc_s  = next_pc_f(io_ctl_pc_sel, pc_r, io_br_target, io_jmp_target,
                                  jalr_clr_s, io_evec);

    // Misalignment uses the pre-exception select so it never loops back through the trap logic.
    always_comb begin
        misaligned_s = 1'b0;
        if (inst_valid_r) begin
            case (io_ctl_pc_sel_no_xept)
                3'd1:    misaligned_s = io_br_target[1];
                3'd2:    misaligned_s = io_jmp_target[1];
                3'd3:    misaligned_s = jalr_clr_s[1];
                default: misaligned_s = 1'b0;
            endcase
        end else begin
            misaligned_s = 1'b0;
        end
    end

    // Fetch FSM, PC and instruction buffer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            inst_r       <= 32'h0000_0000;
            inst_valid_r <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (io_imem_req_ready) begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (io_imem_resp_valid) begin
                        inst_r       <= io_imem_resp_data;
                        inst_valid_r <= 1'b1;
                        state_r      <= HOLD;
                    end
                end
                HOLD: begin
                    if (!io_ctl_stall) begin
                        pc_r         <= next_pc_s;
                        inst_valid_r <= 1'b0;
                        state_r      <= FETCH;
                    end
                end
                default: begin
                    state_r      <= FETCH;
                    inst_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign io_imem_req_valid      = (state_r == FETCH);
    assign io_imem_req_addr       = pc_r;
    assign io_dat_imiss           = (state_r != HOLD);
    assign io_dat_inst_misaligned = misaligned_s;
    assign io_inst                = inst_r;
    assign io_inst_valid          = inst_valid_r;
    assign io_pc                  = pc_r;

endmodule

// File: tb/tb_fetch_unit_1stage.sv
// Directed self-checking bench for fetch_unit_1stage.
module tb_fetch_unit_1stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        stall;
    logic [2:0]  pc_sel;
    logic [2:0]  sel_nx;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] jalr_target;
    logic [31:0] evec;
    logic        imiss;
    logic        misaligned;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;

    int checks   = 0;
    int failures = 0;

    fetch_unit_1stage dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_imem_req_valid     (req_valid),
        .io_imem_req_ready     (req_ready),
        .io_imem_req_addr      (req_addr),
        .io_imem_resp_valid    (resp_valid),
        .io_imem_resp_data     (resp_data),
        .io_ctl_stall          (stall),
        .io_ctl_pc_sel         (pc_sel),
        .io_ctl_pc_sel_no_xept (sel_nx),
        .io_br_target          (br_target),
        .io_jmp_target         (jmp_target),
        .io_jalr_target        (jalr_target),
        .io_evec               (evec),
        .io_dat_imiss          (imiss),
        .io_dat_inst_misaligned(misaligned),
        .io_inst               (inst),
        .io_inst_valid         (inst_valid),
        .io_pc                 (pc)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // From FETCH: accept request, return word d one cycle later, land in HOLD with stall held.
    task automatic fetch_one(input logic [31:0] d);
        stall = 1'b1;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data = d;
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_ready = 1'b0;
        resp_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL rst_req_valid got=%b exp=1", req_valid); end
        checks++; if (req_addr !== 32'h8000_0000) begin failures++; $display("FAIL rst_req_addr got=%h exp=80000000", req_addr); end
        checks++; if (imiss !== 1'b1) begin failures++; $display("FAIL rst_imiss got=%b exp=1", imiss); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst); end
        stall = 1'b1;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        checks++; if (req_valid !== 1'b0 || imiss !== 1'b1) begin failures++; $display("FAIL wait_state req_valid=%b imiss=%b exp 0/1", req_valid, imiss); end
        resp_valid = 1'b1;
        resp_data = 32'h0000_0013;
        tick();
        resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || imiss !== 1'b0) begin failures++; $display("FAIL first_valid inst_valid=%b imiss=%b exp 1/0", inst_valid, imiss); end
        checks++; if (inst !== 32'h0000_0013 || pc !== 32'h8000_0000) begin failures++; $display("FAIL first_inst inst=%h pc=%h exp 00000013/80000000", inst, pc); end
        stall = 1'b0;
        pc_sel = 3'd0;
        tick();
        stall = 1'b1;
        checks++; if (req_addr !== 32'h8000_0004 || req_valid !== 1'b1 || inst_valid !== 1'b0) begin failures++; $display("FAIL seq_next addr=%h valid=%b iv=%b exp 80000004/1/0", req_addr, req_valid, inst_valid); end
    endtask

    task automatic test_req_backpressure();
        do_reset();
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            resp_valid = (i == 2);
            resp_data = 32'hDEAD_BEEF;
            tick();
            checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000 || imiss !== 1'b1) begin failures++; $display("FAIL backpressure[%0d] valid=%b addr=%h imiss=%b exp 1/80000000/1", i, req_valid, req_addr, imiss); end
        end
        resp_valid = 1'b0;
        checks++; if (inst !== 32'h0 || inst_valid !== 1'b0) begin failures++; $display("FAIL resp_in_fetch inst=%h iv=%b exp 0/0", inst, inst_valid); end
        fetch_one(32'h1111_1111);
        checks++; if (inst !== 32'h1111_1111 || inst_valid !== 1'b1) begin failures++; $display("FAIL after_bp inst=%h iv=%b exp 11111111/1", inst, inst_valid); end
    endtask

    task automatic test_ctl_stall();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            resp_valid = (i == 1);
            resp_data = 32'h2222_2222;
            tick();
            checks++; if (inst !== 32'h1111_1111 || pc !== 32'h8000_0000 || inst_valid !== 1'b1 || imiss !== 1'b0) begin failures++; $display("FAIL stall_hold[%0d] inst=%h pc=%h iv=%b imiss=%b", i, inst, pc, inst_valid, imiss); end
        end
        resp_valid = 1'b0;
        stall = 1'b0;
        pc_sel = 3'd1;
        br_target = 32'h8000_0100;
        tick();
        stall = 1'b1;
        pc_sel = 3'd0;
        checks++; if (req_addr !== 32'h8000_0100 || req_valid !== 1'b1) begin failures++; $display("FAIL branch_next addr=%h valid=%b exp 80000100/1", req_addr, req_valid); end
    endtask

    task automatic test_misaligned();
        sel_nx = 3'd3;
        jalr_target = 32'h8000_0203;
        #1;
        checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL misal_no_inst got=%b exp 0", misaligned); end
        fetch_one(32'h3333_3333);
        checks++; if (pc !== 32'h8000_0100 || inst !== 32'h3333_3333) begin failures++; $display("FAIL branch_inst pc=%h inst=%h exp 80000100/33333333", pc, inst); end
        #1;
        checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL misal_jalr_203 got=%b exp 1", misaligned); end
        jalr_target = 32'h8000_0201;
        #1;
        checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL misal_jalr_201 got=%b exp 0", misaligned); end
        sel_nx = 3'd1;
        br_target = 32'h8000_0102;
        #1;
        checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL misal_br got=%b exp 1", misaligned); end
        sel_nx = 3'd0;
        #1;
        checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL misal_sel0 got=%b exp 0", misaligned); end
        pc_sel = 3'd3;
        stall = 1'b0;
        tick();
        stall = 1'b1;
        pc_sel = 3'd0;
        checks++; if (req_addr !== 32'h8000_0200) begin failures++; $display("FAIL jalr_next addr=%h exp 80000200", req_addr); end
    endtask

    task automatic test_xept_priority();
        fetch_one(32'h4444_4444);
        sel_nx = 3'd2;
        jmp_target = 32'h8000_0012;
        pc_sel = 3'd4;
        evec = 32'h8000_0004;
        #1;
        checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL misal_jmp got=%b exp 1", misaligned); end
        stall = 1'b0;
        tick();
        stall = 1'b1;
        pc_sel = 3'd0;
        sel_nx = 3'd0;
        checks++; if (req_addr !== 32'h8000_0004) begin failures++; $display("FAIL evec_next addr=%h exp 80000004", req_addr); end
    endtask

    task automatic test_reset_wait_wrap();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL in_wait req_valid=%b exp 0", req_valid); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000 || inst_valid !== 1'b0) begin failures++; $display("FAIL rst_in_wait valid=%b addr=%h iv=%b exp 1/80000000/0", req_valid, req_addr, inst_valid); end
        fetch_one(32'h5555_5555);
        pc_sel = 3'd1;
        br_target = 32'hFFFF_FFFC;
        stall = 1'b0;
        tick();
        stall = 1'b1;
        pc_sel = 3'd0;
        checks++; if (req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL top_addr addr=%h exp fffffffc", req_addr); end
        fetch_one(32'h6666_6666);
        checks++; if (pc !== 32'hFFFF_FFFC || inst !== 32'h6666_6666) begin failures++; $display("FAIL top_inst pc=%h inst=%h exp fffffffc/66666666", pc, inst); end
        stall = 1'b0;
        tick();
        stall = 1'b1;
        checks++; if (req_addr !== 32'h0000_0000 || req_valid !== 1'b1) begin failures++; $display("FAIL wrap addr=%h valid=%b exp 00000000/1", req_addr, req_valid); end
    endtask

    initial begin
        reset = 1'b0;
        req_ready = 1'b0;
        resp_valid = 1'b0;
        resp_data = 32'h0;
        stall = 1'b1;
        pc_sel = 3'd0;
        sel_nx = 3'd0;
        br_target = 32'h0;
        jmp_target = 32'h0;
        jalr_target = 32'h0;
        evec = 32'h0;
        test_reset();
        test_req_backpressure();
        test_ctl_stall();
        test_misaligned();
        test_xept_priority();
        test_reset_wait_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
